// File: rtl/wbp_pkg.sv
// Shared FSM state type and constants for the writeback_port register-file write driver.
package wbp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PEND
    } wbp_state_e;

    localparam int unsigned BYTE_COUNT = 4;
    localparam int unsigned CNT_W      = $clog2(BYTE_COUNT);

endpackage

// File: rtl/wbp_byte_fifo.sv
// Synchronous byte FIFO with full/empty flags; pointers carry one extra wrap bit.
module wbp_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !full) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/writeback_port.sv
// Register-file write port driver: pipeline results have priority, UART words are assembled
// from four bytes. Define WBP_RX_FIFO_EN to buffer received bytes in a FIFO.
module writeback_port
    import wbp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic        pipe_aorf,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        uart_req,
    input  logic [4:0]  uart_rd,
    input  logic        uart_aorf,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        stall,
    output logic        RegWrite,
    output logic        UART_write_enable,
    output logic        distinct,
    output logic        AorF_before,
    output logic [4:0]  rw,
    output logic [31:0] write_data,
    output logic        err
);

    wbp_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;
    logic [4:0]       lat_rd_q, lat_rd_d;
    logic             lat_aorf_q, lat_aorf_d;

    logic        regwrite_q, regwrite_d;
    logic        uwe_q, uwe_d;
    logic        distinct_q, distinct_d;
    logic        aorf_q, aorf_d;
    logic [4:0]  rw_q, rw_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic       byte_avail;
    logic [7:0] byte_in;
    logic       rx_err;

`ifdef WBP_RX_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    wbp_byte_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .reset    (reset),
        .push     (rx_valid),
        .push_data(rx_data),
        .pop      (byte_avail),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign byte_avail = (state_q == COLLECT) && !fifo_empty;
    assign byte_in    = fifo_data;
    assign rx_err     = rx_valid && fifo_full;
`else
    logic unused_fifo_depth;
    assign unused_fifo_depth = ^FIFO_DEPTH;

    // Without buffering, a byte is only meaningful while a word is being collected.
    assign byte_avail = (state_q == COLLECT) && rx_valid;
    assign byte_in    = rx_data;
    assign rx_err     = rx_valid && (state_q != COLLECT);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        lat_rd_d   = lat_rd_q;
        lat_aorf_d = lat_aorf_q;
        regwrite_d = 1'b0;
        uwe_d      = 1'b0;
        distinct_d = distinct_q;
        aorf_d     = aorf_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        err_d      = err_q | rx_err;

        case (state_q)
            IDLE: begin
                if (uart_req) begin
                    lat_rd_d   = uart_rd;
                    lat_aorf_d = uart_aorf;
                    cnt_d      = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                err_d = err_d | uart_req;
                if (byte_avail) begin
                    word_d = {word_q[23:0], byte_in};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BYTE_COUNT - 1)) begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                err_d = err_d | uart_req;
                if (!pipe_valid) begin
                    uwe_d      = 1'b1;
                    rw_d       = lat_rd_q;
                    aorf_d     = lat_aorf_q;
                    wdata_d    = word_q;
                    distinct_d = ~distinct_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The PEND branch only writes when pipe_valid is low, so this never collides.
        if (pipe_valid) begin
            regwrite_d = 1'b1;
            rw_d       = pipe_rd;
            aorf_d     = pipe_aorf;
            wdata_d    = pipe_data;
            distinct_d = ~distinct_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            lat_rd_q   <= '0;
            lat_aorf_q <= 1'b0;
            regwrite_q <= 1'b0;
            uwe_q      <= 1'b0;
            distinct_q <= 1'b0;
            aorf_q     <= 1'b0;
            rw_q       <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            lat_rd_q   <= lat_rd_d;
            lat_aorf_q <= lat_aorf_d;
            regwrite_q <= regwrite_d;
            uwe_q      <= uwe_d;
            distinct_q <= distinct_d;
            aorf_q     <= aorf_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign stall             = (state_q != IDLE) || uart_req;
    assign RegWrite          = regwrite_q;
    assign UART_write_enable = uwe_q;
    assign distinct          = distinct_q;
    assign AorF_before       = aorf_q;
    assign rw                = rw_q;
    assign write_data        = wdata_q;
    assign err               = err_q;

endmodule

// File: tb/tb_writeback_port.sv
// Scoreboard bench for writeback_port: directed scenarios followed by randomized traffic.
module tb_writeback_port;

    localparam int FIFO_DEPTH = 8;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_valid = 1'b0;
    logic        pipe_aorf = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        uart_req = 1'b0;
    logic [4:0]  uart_rd = '0;
    logic        uart_aorf = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        stall;
    logic        RegWrite;
    logic        UART_write_enable;
    logic        distinct;
    logic        AorF_before;
    logic [4:0]  rw;
    logic [31:0] write_data;
    logic        err;

    writeback_port #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK              (CLK),
        .reset            (reset),
        .pipe_valid       (pipe_valid),
        .pipe_aorf        (pipe_aorf),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .uart_req         (uart_req),
        .uart_rd          (uart_rd),
        .uart_aorf        (uart_aorf),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .stall            (stall),
        .RegWrite         (RegWrite),
        .UART_write_enable(UART_write_enable),
        .distinct         (distinct),
        .AorF_before      (AorF_before),
        .rw               (rw),
        .write_data       (write_data),
        .err              (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        uart;
        logic        aorf;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    // Reference model: what the write port should present after the coming edge.
    logic       exp_wr;
    logic       m_distinct, m_err;
    logic       m_collecting, m_ready;
    int         m_nbytes;
    logic [31:0] m_word;
    logic [4:0] m_rd;
    logic       m_aorf;
    wr_t        m_last;
    logic [7:0] rxq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_wr       = 1'b0;
        m_distinct   = 1'b0;
        m_err        = 1'b0;
        m_collecting = 1'b0;
        m_ready      = 1'b0;
        m_nbytes     = 0;
        m_word       = '0;
        m_rd         = '0;
        m_aorf       = 1'b0;
        m_last       = '{uart: 1'b0, aorf: 1'b0, rd: 5'd0, data: 32'd0};
        sb.delete();
        rxq.delete();
    endtask

    task automatic take_byte(input logic [7:0] b);
        m_word = {m_word[23:0], b};
        m_nbytes++;
        if (m_nbytes == 4) begin
            m_collecting = 1'b0;
            m_ready      = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset      = 1'b1;
        pipe_valid = 1'b0;
        uart_req   = 1'b0;
        rx_valid   = 1'b0;
        model_clear();
        @(posedge CLK);
        mon_en = 1'b1;
    endtask

    task automatic cycle(input logic pv, input logic paorf, input logic [4:0] prd,
                         input logic [31:0] pdata, input logic ureq, input logic [4:0] urd,
                         input logic uaorf, input logic rxv, input logic [7:0] rxd);
        logic busy;
        wr_t  e;
        @(negedge CLK);
        reset      = 1'b0;
        pipe_valid = pv;
        pipe_aorf  = paorf;
        pipe_rd    = prd;
        pipe_data  = pdata;
        uart_req   = ureq;
        uart_rd    = urd;
        uart_aorf  = uaorf;
        rx_valid   = rxv;
        rx_data    = rxd;
        busy = m_collecting || m_ready;
        #1;
        chk("stall", 64'(stall), 64'(busy || ureq));

        exp_wr = 1'b0;
        if (pv) begin
            e = '{uart: 1'b0, aorf: paorf, rd: prd, data: pdata};
            exp_wr = 1'b1;
        end else if (m_ready) begin
            e = '{uart: 1'b1, aorf: m_aorf, rd: m_rd, data: m_word};
            m_ready = 1'b0;
            exp_wr  = 1'b1;
        end
        if (exp_wr) begin
            sb.push_back(e);
            m_last     = e;
            m_distinct = ~m_distinct;
        end

`ifdef WBP_RX_FIFO_EN
        begin
            logic full;
            full = (rxq.size() == FIFO_DEPTH);
            if (m_collecting && rxq.size() > 0) take_byte(rxq.pop_front());
            if (rxv) begin
                if (full) m_err = 1'b1;
                else rxq.push_back(rxd);
            end
        end
`else
        if (rxv) begin
            if (m_collecting) take_byte(rxd);
            else m_err = 1'b1;
        end
`endif

        if (ureq) begin
            if (busy) begin
                m_err = 1'b1;
            end else begin
                m_collecting = 1'b1;
                m_nbytes     = 0;
                m_rd         = urd;
                m_aorf       = uaorf;
            end
        end
        @(posedge CLK);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] data, input logic aorf);
        cycle(1'b1, aorf, rd, data, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic req(input logic [4:0] rd, input logic aorf);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, rd, aorf, 1'b0, 8'd0);
    endtask

    task automatic rxb(input logic [7:0] b);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, b);
    endtask

    // Monitor: compares registered outputs against the scoreboard each cycle.
    always @(posedge CLK) begin
        #1;
        if (mon_en) begin
            chk("write_strobe", 64'(RegWrite || UART_write_enable), 64'(exp_wr));
            chk("single_source", 64'(RegWrite && UART_write_enable), 64'd0);
            if (RegWrite || UART_write_enable) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("uart_src", 64'(UART_write_enable), 64'(e.uart));
                    chk("wr_rd", 64'(rw), 64'(e.rd));
                    chk("wr_data", 64'(write_data), 64'(e.data));
                    chk("wr_aorf", 64'(AorF_before), 64'(e.aorf));
                end
            end
            chk("distinct", 64'(distinct), 64'(m_distinct));
            chk("err", 64'(err), 64'(m_err));
            chk("hold_rw", 64'(rw), 64'(m_last.rd));
            chk("hold_data", 64'(write_data), 64'(m_last.data));
            chk("hold_aorf", 64'(AorF_before), 64'(m_last.aorf));
        end
    end

    initial begin
        model_clear();
        do_reset();
        idle();

        pipe(5'd5, 32'h1234_5678, 1'b0);
        idle();

        pipe(5'd1, 32'hAAAA_0001, 1'b0);
        pipe(5'd2, 32'hAAAA_0002, 1'b1);
        pipe(5'd0, 32'hAAAA_0003, 1'b0);
        idle();

        req(5'd3, 1'b1);
        rxb(8'h3F);
        rxb(8'h80);
        rxb(8'h00);
        rxb(8'h00);
        idle();
        idle();
        idle();

        req(5'd7, 1'b0);
        rxb(8'hDE);
        rxb(8'hAD);
        rxb(8'hBE);
        cycle(1'b1, 1'b0, 5'd9, 32'h0000_0009, 1'b0, 5'd0, 1'b0, 1'b1, 8'hEF);
        pipe(5'd10, 32'h0000_000A, 1'b1);
        idle();
        idle();

        req(5'd4, 1'b0);
        rxb(8'h11);
        rxb(8'h22);
        do_reset();
        idle();
        req(5'd6, 1'b1);
        rxb(8'hC0);
        rxb(8'hFF);
        rxb(8'hEE);
        rxb(8'h01);
        idle();
        idle();

`ifdef WBP_RX_FIFO_EN
        do_reset();
        for (int i = 1; i <= 9; i++) rxb(8'(i));
        req(5'd12, 1'b0);
        for (int i = 0; i < 8; i++) idle();
`endif

        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                logic ureq;
                ureq = (!(m_collecting || m_ready) && $urandom_range(0, 9) < 3) ||
                       ($urandom_range(0, 39) == 0);
                cycle($urandom_range(0, 9) < 4, 1'($urandom), 5'($urandom), $urandom,
                      ureq, 5'($urandom), 1'($urandom), $urandom_range(0, 9) < 5,
                      8'($urandom));
            end
            for (int c = 0; c < 20; c++) idle();
            chk("sb_drained", 64'(sb.size()), 64'd0);
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
